// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request/response handshake bundle for both ALU arbiter ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_opcode;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic [3:0]        req0_imm;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_result;
    logic [1:0]        rsp0_flag;
    logic              rsp0_ctrl;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_opcode;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic [3:0]        req1_imm;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_result;
    logic [1:0]        rsp1_flag;
    logic              rsp1_ctrl;
    logic              rsp1_err;

    modport master (
        output req0_valid, req0_opcode, req0_op1, req0_op2, req0_imm, rsp0_ready,
        output req1_valid, req1_opcode, req1_op1, req1_op2, req1_imm, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_flag, rsp0_ctrl, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_flag, rsp1_ctrl, rsp1_err
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_op1, req0_op2, req0_imm, rsp0_ready,
        input  req1_valid, req1_opcode, req1_op1, req1_op2, req1_imm, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_flag, rsp0_ctrl, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_flag, rsp1_ctrl, rsp1_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one registered ALU between two ports.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_arbiter_if.slave      bus,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operand_one,
    output logic [DATA_W-1:0] alu_operand_two,
    output logic [3:0]        alu_imm_value,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [1:0]        alu_flag,
    output logic              busy
);

    localparam int                 c_CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ALU_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_live;
    logic                r_cur;
    logic                r_last_grant;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [3:0]          r_alu_opcode;
    logic [DATA_W-1:0]   r_alu_op1;
    logic [DATA_W-1:0]   r_alu_op2;
    logic [3:0]          r_alu_imm;
    logic [DATA_W-1:0]   r_result;
    logic [1:0]          r_flag;
    logic                r_ctrl;
    logic                r_err;

    logic w_tie;
    logic w_pick1;
    logic w_open;
    logic w_accept;
    logic w_pending;
    logic w_capture;
    logic w_rsp_ready;
    logic w_ctrl;
    logic w_err;

    always_comb begin
        w_tie       = bus.req0_valid & bus.req1_valid;
        // On a tie the port that did not win last time goes next.
        w_pick1     = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
        w_open      = (r_state == IDLE) & r_live;
        w_accept    = w_open & (bus.req0_valid | bus.req1_valid);
        w_pending   = (r_state == ISSUE) | (r_state == WAIT);
        // Counting starts on the issue edge, so the capture edge falls one
        // edge after the ALU result register has taken the new answer.
        w_capture   = w_pending & (r_cnt == c_LAST);
        w_rsp_ready = r_cur ? bus.rsp1_ready : bus.rsp0_ready;
        w_ctrl      = (r_alu_opcode == 4'b1000) | (r_alu_opcode == 4'b1001) |
                      (r_alu_opcode == 4'b1010) | (r_alu_opcode == 4'b1111);
        w_err       = ((r_alu_opcode == 4'b0110) & (r_alu_op2 == '0)) |
                      ((r_alu_opcode == 4'b0111) & (r_alu_imm == 4'd0));

        w_state_nxt = r_state;
        case (r_state)
            IDLE:        if (w_accept) w_state_nxt = ISSUE;
            ISSUE, WAIT: w_state_nxt = w_capture ? RESP : WAIT;
            RESP:        if (w_rsp_ready) w_state_nxt = IDLE;
            default:     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_live       <= 1'b0;
            r_cur        <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_imm    <= '0;
            r_result     <= '0;
            r_flag       <= '0;
            r_ctrl       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_cur        <= w_pick1;
                r_last_grant <= w_pick1;
                r_cnt        <= '0;
                r_alu_opcode <= w_pick1 ? bus.req1_opcode : bus.req0_opcode;
                r_alu_op1    <= w_pick1 ? bus.req1_op1    : bus.req0_op1;
                r_alu_op2    <= w_pick1 ? bus.req1_op2    : bus.req0_op2;
                r_alu_imm    <= w_pick1 ? bus.req1_imm    : bus.req0_imm;
            end else if (w_capture) begin
                r_result <= w_err ? '0 : alu_result;
                r_flag   <= w_ctrl ? alu_flag : 2'b00;
                r_ctrl   <= w_ctrl;
                r_err    <= w_err;
            end else if (w_pending) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.req0_ready  = w_open & ~(w_tie & w_pick1);
        bus.req1_ready  = w_open & ~(w_tie & ~w_pick1);
        bus.rsp0_valid  = 1'b0;
        bus.rsp0_result = '0;
        bus.rsp0_flag   = 2'b00;
        bus.rsp0_ctrl   = 1'b0;
        bus.rsp0_err    = 1'b0;
        bus.rsp1_valid  = 1'b0;
        bus.rsp1_result = '0;
        bus.rsp1_flag   = 2'b00;
        bus.rsp1_ctrl   = 1'b0;
        bus.rsp1_err    = 1'b0;
        if (r_state == RESP) begin
            if (r_cur) begin
                bus.rsp1_valid  = 1'b1;
                bus.rsp1_result = r_result;
                bus.rsp1_flag   = r_flag;
                bus.rsp1_ctrl   = r_ctrl;
                bus.rsp1_err    = r_err;
            end else begin
                bus.rsp0_valid  = 1'b1;
                bus.rsp0_result = r_result;
                bus.rsp0_flag   = r_flag;
                bus.rsp0_ctrl   = r_ctrl;
                bus.rsp0_err    = r_err;
            end
        end
    end

    assign alu_opcode      = r_alu_opcode;
    assign alu_operand_one = r_alu_op1;
    assign alu_operand_two = r_alu_op2;
    assign alu_imm_value   = r_alu_imm;
    assign busy            = (r_state != IDLE);

endmodule
`default_nettype wire
